// File: rtl/usb_pkg.sv
// Shared types and defaults for the host-side USB transaction controller.
// Holds the controller state encoding and the retry/timeout defaults.
package usb_pkg;

   typedef enum logic [3:0] {
      IDLE,
      R_TOKEN,
      R_WAIT,
      R_ACK,
      R_NAK,
      W_TOKEN,
      W_DATA,
      W_WAIT,
      FINISH
   } state_t;

   localparam int unsigned DEF_MAX_ATTEMPTS = 8;
   localparam int unsigned DEF_TIMEOUT      = 255;

   function automatic logic is_wait_state(input state_t s);
      return (s == R_WAIT) || (s == W_WAIT);
   endfunction

endpackage

// File: rtl/ph_timeout_counter.sv
// Device-response timer for the wait states: cleared outside the wait,
// counts while enabled, freezes while a device packet is arriving.
module ph_timeout_counter
   import usb_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   input  logic hold,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable && !hold && (r_count != LIMIT)) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign expired = enable && (r_count == LIMIT);

endmodule

// File: rtl/ph_transaction_ctrl.sv
// Host transaction controller: sequences IN/OUT token, data and handshake
// packets, retries failed attempts and reports completion status.
module ph_transaction_ctrl
   import usb_pkg::*;
#(
   parameter int unsigned MAX_ATTEMPTS = DEF_MAX_ATTEMPTS,
   parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start_read,
   input  logic        start_write,
   input  logic [63:0] write_data,
   input  logic        tx_done,
   input  logic        rec_start,
   input  logic        rec_ACK,
   input  logic        rec_NAK,
   input  logic        rec_DATA0,
   input  logic        data_valid,
   input  logic [63:0] data_rec,
   output logic        send_IN,
   output logic        send_OUT,
   output logic        send_DATA0,
   output logic        send_ACK,
   output logic        send_NAK,
   output logic [63:0] tx_data,
   output logic        host_sending,
   output logic [63:0] read_data,
   output logic        busy,
   output logic        done,
   output logic        success
);

   localparam logic [3:0] ATT_LIMIT = 4'(MAX_ATTEMPTS);

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_attempts;
   logic        r_success;
   logic [63:0] r_read_data;
   logic [63:0] r_tx_data;
   logic        w_in_wait;
   logic        w_expired;
   logic        w_fail;
   logic        w_win;
   logic        w_last_attempt;
   logic        w_accept;
   logic        w_good_data;

   assign w_in_wait      = is_wait_state(r_state);
   assign w_last_attempt = ((r_attempts + 4'd1) == ATT_LIMIT);
   assign w_accept       = (r_state == IDLE) && (start_read || start_write);
   assign w_good_data    = rec_DATA0 && data_valid;

   ph_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (!w_in_wait),
      .enable  (w_in_wait),
      .hold    (rec_start),
      .expired (w_expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_fail       = 1'b0;
      w_win        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_read)       w_next_state = R_TOKEN;
            else if (start_write) w_next_state = W_TOKEN;
         end
         R_TOKEN: if (tx_done) w_next_state = R_WAIT;
         R_WAIT: begin
            // A device response in the expiry cycle takes priority over the timeout.
            if (w_good_data) begin
               w_next_state = R_ACK;
            end else if (rec_DATA0) begin
               w_fail       = 1'b1;
               w_next_state = w_last_attempt ? FINISH : R_NAK;
            end else if (w_expired) begin
               w_fail       = 1'b1;
               w_next_state = w_last_attempt ? FINISH : R_TOKEN;
            end
         end
         R_ACK: begin
            if (tx_done) begin
               w_win        = 1'b1;
               w_next_state = FINISH;
            end
         end
         R_NAK:   if (tx_done) w_next_state = R_WAIT;
         W_TOKEN: if (tx_done) w_next_state = W_DATA;
         W_DATA:  if (tx_done) w_next_state = W_WAIT;
         W_WAIT: begin
            if (rec_ACK) begin
               w_win        = 1'b1;
               w_next_state = FINISH;
            end else if (rec_NAK || w_expired) begin
               w_fail       = 1'b1;
               w_next_state = w_last_attempt ? FINISH : W_DATA;
            end
         end
         FINISH:  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_attempts  <= '0;
         r_success   <= 1'b0;
         r_read_data <= '0;
         r_tx_data   <= '0;
      end else begin
         if (w_accept) begin
            r_attempts <= '0;
            r_success  <= 1'b0;
         end else if (w_fail) begin
            r_attempts <= r_attempts + 4'd1;
         end
         if (w_win) begin
            r_success <= 1'b1;
         end
         if ((r_state == IDLE) && !start_read && start_write) begin
            r_tx_data <= write_data;
         end
         if ((r_state == R_WAIT) && w_good_data) begin
            r_read_data <= data_rec;
         end
      end
   end

   // Outputs depend on state only, so reset clears them in the same cycle.
   assign send_IN      = (r_state == R_TOKEN);
   assign send_OUT     = (r_state == W_TOKEN);
   assign send_DATA0   = (r_state == W_DATA);
   assign send_ACK     = (r_state == R_ACK);
   assign send_NAK     = (r_state == R_NAK);
   assign host_sending = send_IN | send_OUT | send_DATA0 | send_ACK | send_NAK;
   assign busy         = (r_state != IDLE);
   assign done         = (r_state == FINISH);
   assign success      = done && r_success;
   assign tx_data      = r_tx_data;
   assign read_data    = r_read_data;

endmodule

// File: tb/tb_ph_transaction_ctrl.sv
// Self-checking bench for ph_transaction_ctrl: a sender model scoreboards
// every host packet against an expected queue; a table drives transactions.
module tb_ph_transaction_ctrl;
   import usb_pkg::*;

   localparam int MAX_ATT = 8;
   localparam int TMO     = 255;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start_read, start_write, tx_done, rec_start;
   logic        rec_ACK, rec_NAK, rec_DATA0, data_valid;
   logic [63:0] write_data, data_rec;
   logic        send_IN, send_OUT, send_DATA0, send_ACK, send_NAK;
   logic [63:0] tx_data, read_data;
   logic        host_sending, busy, done, success;

   typedef enum int {P_IN, P_OUT, P_DATA0, P_ACK, P_NAK} pkt_t;
   typedef struct {
      pkt_t        kind;
      logic [63:0] data;
   } pkt_rec_t;

   typedef struct {
      bit          is_write;
      logic [63:0] payload;
      int          n_bad;
      bit          exp_success;
      int          exp_attempts;
   } vec_t;

   pkt_rec_t    exp_q[$];
   int          n_checks = 0;
   int          n_failures = 0;
   int          wait_cycles = 0;
   logic [63:0] exp_read = '0;
   logic [63:0] exp_tx = '0;
   vec_t        vecs[6];

   ph_transaction_ctrl #(.MAX_ATTEMPTS(MAX_ATT), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset_n(reset_n),
      .start_read(start_read), .start_write(start_write), .write_data(write_data),
      .tx_done(tx_done), .rec_start(rec_start),
      .rec_ACK(rec_ACK), .rec_NAK(rec_NAK), .rec_DATA0(rec_DATA0),
      .data_valid(data_valid), .data_rec(data_rec),
      .send_IN(send_IN), .send_OUT(send_OUT), .send_DATA0(send_DATA0),
      .send_ACK(send_ACK), .send_NAK(send_NAK), .tx_data(tx_data),
      .host_sending(host_sending), .read_data(read_data),
      .busy(busy), .done(done), .success(success)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void push(input pkt_t k, input logic [63:0] d);
      pkt_rec_t p;
      p.kind = k;
      p.data = d;
      exp_q.push_back(p);
   endfunction

   // Host sender model: records each packet, acks it with tx_done 3 cycles later.
   initial begin : sender
      pkt_t     kind;
      pkt_rec_t e;
      tx_done = 1'b0;
      forever begin
         @(negedge clock);
         if (reset_n && host_sending) begin
            check("send_onehot", 64'($onehot({send_IN, send_OUT, send_DATA0, send_ACK, send_NAK})), 64'd1);
            if (send_IN)         kind = P_IN;
            else if (send_OUT)   kind = P_OUT;
            else if (send_DATA0) kind = P_DATA0;
            else if (send_ACK)   kind = P_ACK;
            else                 kind = P_NAK;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_failures++;
               $display("FAIL unexpected_packet: got %s expected none", kind.name());
            end else begin
               e = exp_q.pop_front();
               check($sformatf("pkt_kind_%s", e.kind.name()), 64'(kind), 64'(e.kind));
               if (kind == P_DATA0) check("pkt_tx_data", tx_data, e.data);
            end
            repeat (3) @(negedge clock);
            tx_done = 1'b1;
            @(negedge clock);
            tx_done = 1'b0;
         end
      end
   end

   initial begin : wait_monitor
      forever begin
         @(negedge clock);
         if (busy && !host_sending && !done) wait_cycles++;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic start(input bit rd, input bit wr, input logic [63:0] d);
      start_read  = rd;
      start_write = wr;
      write_data  = d;
      @(negedge clock);
      start_read  = 1'b0;
      start_write = 1'b0;
      write_data  = $urandom();
   endtask

   task automatic pulse(input bit ack, input bit nak, input bit d0, input bit dv, input logic [63:0] d);
      rec_ACK   = ack;
      rec_NAK   = nak;
      rec_DATA0 = d0;
      data_valid = dv;
      data_rec  = d;
      @(negedge clock);
      rec_ACK = 1'b0; rec_NAK = 1'b0; rec_DATA0 = 1'b0; data_valid = 1'b0;
      data_rec = {$urandom(), $urandom()};
   endtask

   task automatic wait_window(input string tag);
      int n = 0;
      while (!(busy && !host_sending && !done) && n < 1000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 1000) begin
         n_checks++;
         n_failures++;
         $display("FAIL %s_window_timeout: got no wait state expected one within 1000 cycles", tag);
      end
   endtask

   task automatic wait_done(input int budget, input bit exp_s, input string tag);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (!done) begin
         n_checks++;
         n_failures++;
         $display("FAIL %s_done_timeout: got no done expected done within %0d cycles", tag, budget);
      end else begin
         check({tag, "_success"}, 64'(success), 64'(exp_s));
         @(negedge clock);
         check({tag, "_done_one_cycle"}, {62'd0, done, busy}, 64'd0);
      end
   endtask

   task automatic good_read(input logic [63:0] d, input string tag);
      wait_window(tag);
      rec_start = 1'b1;
      repeat (2) @(negedge clock);
      rec_start = 1'b0;
      pulse(1'b0, 1'b0, 1'b1, 1'b1, d);
      exp_read = d;
   endtask

   initial begin : main
      string tag;
      int    w0;
      reset_n = 1'b0;
      start_read = 1'b0; start_write = 1'b0; write_data = '0;
      rec_start = 1'b0; rec_ACK = 1'b0; rec_NAK = 1'b0; rec_DATA0 = 1'b0;
      data_valid = 1'b0; data_rec = '0;

      vecs[0] = '{1'b0, 64'hDEAD_BEEF_0123_4567, 0, 1'b1, 0};
      vecs[1] = '{1'b0, 64'hCAFE_F00D_1357_9BDF, 2, 1'b1, 2};
      vecs[2] = '{1'b1, 64'h0011_2233_4455_6677, 2, 1'b1, 2};
      vecs[3] = '{1'b1, 64'hA5A5_5A5A_F0F0_0F0F, 0, 1'b1, 0};
      vecs[4] = '{1'b0, 64'h1111_2222_3333_4444, 8, 1'b0, 8};
      vecs[5] = '{1'b1, 64'h8765_4321_8765_4321, 8, 1'b0, 8};

      repeat (3) @(negedge clock);
      check("reset_status", {51'd0, send_IN, send_OUT, send_DATA0, send_ACK, send_NAK,
                             host_sending, busy, done, success, 4'd0}, 64'd0);
      check("reset_read_data", read_data, 64'd0);
      check("reset_tx_data", tx_data, 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int v = 0; v < 6; v++) begin
         tag = $sformatf("vec%0d", v);
         if (vecs[v].is_write) begin
            exp_tx = vecs[v].payload;
            push(P_OUT, 'x);
            push(P_DATA0, exp_tx);
            for (int i = 1; i <= vecs[v].n_bad; i++) if (i < MAX_ATT) push(P_DATA0, exp_tx);
            if (vecs[v].n_bad >= MAX_ATT) ; else ;
            start(1'b0, 1'b1, exp_tx);
            for (int i = 0; i < vecs[v].n_bad && i < MAX_ATT; i++) begin
               wait_window(tag);
               pulse(1'b0, 1'b1, 1'b0, 1'b0, '0);
            end
            if (vecs[v].n_bad < MAX_ATT) begin
               wait_window(tag);
               pulse(1'b0, 1'b0, 1'b1, 1'b1, 64'h5555_0000_5555_0000);
               pulse(1'b1, 1'b0, 1'b0, 1'b0, '0);
            end
         end else begin
            push(P_IN, 'x);
            for (int i = 1; i <= vecs[v].n_bad; i++) if (i < MAX_ATT) push(P_NAK, 'x);
            if (vecs[v].n_bad < MAX_ATT) push(P_ACK, 'x);
            start(1'b1, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0);
            for (int i = 0; i < vecs[v].n_bad && i < MAX_ATT; i++) begin
               wait_window(tag);
               pulse(1'b0, 1'b0, 1'b1, 1'b0, 64'hEEEE_EEEE_EEEE_EEEE);
            end
            if (vecs[v].n_bad < MAX_ATT) begin
               wait_window(tag);
               pulse(1'b1, 1'b0, 1'b0, 1'b0, '0);
               pulse(1'b0, 1'b1, 1'b0, 1'b0, '0);
               good_read(vecs[v].payload, tag);
            end
         end
         wait_done(200, vecs[v].exp_success, tag);
         check({tag, "_attempts"}, 64'(dut.r_attempts), 64'(vecs[v].exp_attempts));
         check({tag, "_read_data"}, read_data, exp_read);
         check({tag, "_tx_data"}, tx_data, exp_tx);
         check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
      end

      // Simultaneous starts: read wins; a write while busy is dropped.
      push(P_IN, 'x);
      push(P_ACK, 'x);
      start(1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000);
      start(1'b0, 1'b1, 64'h1234_1234_1234_1234);
      good_read(64'h0BAD_CAFE_0BAD_CAFE, "both_starts");
      wait_done(200, 1'b1, "both_starts");
      check("both_starts_tx_data", tx_data, exp_tx);
      check("both_starts_read_data", read_data, exp_read);
      check("both_starts_queue", 64'(exp_q.size()), 64'd0);

      // Good DATA0 in the very cycle the timer reaches TIMEOUT must win.
      push(P_IN, 'x);
      push(P_ACK, 'x);
      start(1'b1, 1'b0, '0);
      wait_window("tmo_race");
      repeat (TMO) @(negedge clock);
      pulse(1'b0, 1'b0, 1'b1, 1'b1, 64'h7E57_7E57_7E57_7E57);
      exp_read = 64'h7E57_7E57_7E57_7E57;
      wait_done(200, 1'b1, "tmo_race");
      check("tmo_race_read_data", read_data, exp_read);
      check("tmo_race_attempts", 64'(dut.r_attempts), 64'd0);

      // Silent device on write: eight timeouts, eight DATA0 sends, failure.
      exp_tx = 64'h0F0F_1E1E_2D2D_3C3C;
      push(P_OUT, 'x);
      for (int i = 0; i < MAX_ATT; i++) push(P_DATA0, exp_tx);
      w0 = wait_cycles;
      start(1'b0, 1'b1, exp_tx);
      wait_done(4000, 1'b0, "silent_write");
      check("silent_write_queue", 64'(exp_q.size()), 64'd0);
      check("silent_write_attempts", 64'(dut.r_attempts), 64'(MAX_ATT));
      if (!((wait_cycles - w0) >= MAX_ATT * TMO && (wait_cycles - w0) <= MAX_ATT * (TMO + 2))) begin
         n_checks++;
         n_failures++;
         $display("FAIL silent_write_wait_cycles: got %0d expected %0d..%0d",
                  wait_cycles - w0, MAX_ATT * TMO, MAX_ATT * (TMO + 2));
      end else begin
         n_checks++;
      end

      // Reset while DATA0 is being sent clears outputs immediately.
      push(P_OUT, 'x);
      push(P_DATA0, 64'h4242_4242_4242_4242);
      start(1'b0, 1'b1, 64'h4242_4242_4242_4242);
      for (int n = 0; n < 100 && !send_DATA0; n++) @(negedge clock);
      check("mid_send_data0_seen", 64'(send_DATA0), 64'd1);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("mid_send_reset_status", {54'd0, send_IN, send_OUT, send_DATA0, send_ACK, send_NAK,
                                      host_sending, busy, done, success, 1'b0}, 64'd0);
      check("mid_send_reset_tx_data", tx_data, 64'd0);
      exp_read = '0;
      exp_tx   = '0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (10) @(negedge clock);
      check("mid_send_queue", 64'(exp_q.size()), 64'd0);
      push(P_IN, 'x);
      push(P_ACK, 'x);
      start(1'b1, 1'b0, '0);
      good_read(64'h600D_600D_600D_600D, "after_reset");
      wait_done(200, 1'b1, "after_reset");
      check("after_reset_read_data", read_data, exp_read);
      check("after_reset_queue", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
